// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF requester, DM requester and shared memory port signals.
//   slave  : arbiter side (samples requests and mem_rdata, drives acks,
//            read data, mux select, memory strobes and busy)
//   master : environment side (requesters plus the memory model)
interface mem_port_arbiter_if;
  logic        if_req;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_sel;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, dm_req, dm_we, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_sel, mem_en, mem_we, busy
  );

  modport master (
    output if_req, dm_req, dm_we, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_sel, mem_en, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch (IF) and data
// memory (DM). DM has priority; after MAX_WAIT consecutive contended DM wins
// IF wins the next contention. Each access is a fixed-latency sequence and
// the select for the external address/data muxes is held for its duration.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave
//          if_req/dm_req/dm_we in, if_ack/dm_ack + if_rdata/dm_rdata out,
//          mem_sel/mem_en/mem_we out, mem_rdata in, busy out
//
// state | meaning
// IDLE  | waiting for a request, arbitration happens here
// ISSUE | one-cycle memory strobe, latency counter loaded
// WAIT  | LAT cycles until mem_rdata is valid, data captured on the last one
// RESP  | one-cycle ack to the winner
module mem_port_arbiter #(
  parameter int unsigned LAT      = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_W  = 4'(LAT);
  localparam logic [3:0] MAX_W  = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;        // 0 = IF, 1 = DM
  logic        we_q, we_d;
  logic [3:0]  wait_q, wait_d;      // contended DM wins since IF last won
  logic [3:0]  lat_q, lat_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      wait_q     <= 4'd0;
      lat_q      <= 4'd0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      wait_q     <= wait_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    wait_d     = wait_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      IDLE: begin
        // IF only beats DM when it has been passed over MAX_WAIT times
        if (bus.dm_req && !(bus.if_req && (wait_q == MAX_W))) begin
          sel_d   = 1'b1;
          we_d    = bus.dm_we;
          state_d = ISSUE;
          if (bus.if_req && (wait_q < MAX_W)) begin
            wait_d = wait_q + 4'd1;
          end
        end else if (bus.if_req) begin
          sel_d   = 1'b0;
          we_d    = 1'b0;
          wait_d  = 4'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_W;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          // writes leave the read-data registers untouched
          if (!sel_q) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_sel  = sel_q;
  assign bus.mem_en   = (state_q == ISSUE);
  assign bus.mem_we   = (state_q == ISSUE) && sel_q && we_q;
  assign bus.if_ack   = (state_q == RESP) && !sel_q;
  assign bus.dm_ack   = (state_q == RESP) && sel_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  if_req, dm_req, dm_we;
  logic [31:0] mem_rdata [2];
  logic [1:0]  o_if_ack, o_dm_ack, o_sel, o_en, o_we, o_busy;
  logic [31:0] o_if_rdata [2];
  logic [31:0] o_dm_rdata [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter_if bus_if ();
    mem_port_arbiter #(.LAT((g == 0) ? 1 : 3), .MAX_WAIT(MAX_WAIT)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
    );
    assign bus_if.if_req    = if_req[g];
    assign bus_if.dm_req    = dm_req[g];
    assign bus_if.dm_we     = dm_we[g];
    assign bus_if.mem_rdata = mem_rdata[g];
    assign o_if_ack[g]      = bus_if.if_ack;
    assign o_dm_ack[g]      = bus_if.dm_ack;
    assign o_sel[g]         = bus_if.mem_sel;
    assign o_en[g]          = bus_if.mem_en;
    assign o_we[g]          = bus_if.mem_we;
    assign o_busy[g]        = bus_if.busy;
    assign o_if_rdata[g]    = bus_if.if_rdata;
    assign o_dm_rdata[g]    = bus_if.dm_rdata;
  end

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", name, i, cyc, act, exp);
    end
  endtask

  // Transaction-level model: an access is a timeline of offsets from the
  // cycle it was granted; outputs are functions of that offset.
  bit        m_act [2];
  bit        m_dm  [2];
  bit        m_we  [2];
  int        m_n   [2];
  int        m_wait[2];
  bit [31:0] m_ifd [2];
  bit [31:0] m_dmd [2];
  bit [1:0]  e_busy, e_en, e_we, e_ifack, e_dmack, e_sel;
  bit [31:0] e_ifd [2];
  bit [31:0] e_dmd [2];

  always @(posedge clk) begin : model_p
    bit act, dm, we;
    int n, wt, L;
    bit [31:0] ifd, dmd;
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      L = lat_of(i);
      act = m_act[i]; dm = m_dm[i]; we = m_we[i];
      n = m_n[i]; wt = m_wait[i]; ifd = m_ifd[i]; dmd = m_dmd[i];
      if (rst) begin
        act = 0; dm = 0; we = 0; n = 0; wt = 0; ifd = 0; dmd = 0;
      end else if (act) begin
        n = n + 1;
        if (n == L + 2) begin
          if (!dm) ifd = mem_rdata[i];
          else if (!we) dmd = mem_rdata[i];
        end
        if (n == L + 3) act = 0;
      end else if (if_req[i] || dm_req[i]) begin
        dm = dm_req[i] && !(if_req[i] && wt == MAX_WAIT);
        if (!dm) wt = 0;
        else if (if_req[i] && wt < MAX_WAIT) wt = wt + 1;
        we  = dm && dm_we[i];
        act = 1;
        n   = 1;
      end
      m_act[i] <= act; m_dm[i] <= dm; m_we[i] <= we; m_n[i] <= n;
      m_wait[i] <= wt; m_ifd[i] <= ifd; m_dmd[i] <= dmd;
      e_busy[i]  <= act;
      e_en[i]    <= act && n == 1;
      e_we[i]    <= act && n == 1 && dm && we;
      e_ifack[i] <= act && n == L + 2 && !dm;
      e_dmack[i] <= act && n == L + 2 && dm;
      e_sel[i]   <= dm;
      e_ifd[i]   <= ifd;
      e_dmd[i]   <= dmd;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy",     i, 32'(o_busy[i]),   32'(e_busy[i]));
        chk("mem_en",   i, 32'(o_en[i]),     32'(e_en[i]));
        chk("mem_we",   i, 32'(o_we[i]),     32'(e_we[i]));
        chk("mem_sel",  i, 32'(o_sel[i]),    32'(e_sel[i]));
        chk("if_ack",   i, 32'(o_if_ack[i]), 32'(e_ifack[i]));
        chk("dm_ack",   i, 32'(o_dm_ack[i]), 32'(e_dmack[i]));
        chk("if_rdata", i, o_if_rdata[i],    e_ifd[i]);
        chk("dm_rdata", i, o_dm_rdata[i],    e_dmd[i]);
      end
    end
  end

  // Stimulus side: requesters and a fixed-latency memory.
  bit          rnd_tok;
  logic [31:0] tok [2];
  bit          keep_if [2];
  bit          keep_dm [2];
  logic [15:0] hist [2];

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      hist[i] = {hist[i][14:0], o_en[i]};
      if (rnd_tok) tok[i] = $urandom;
      mem_rdata[i] = hist[i][lat_of(i)] ? tok[i] : 32'hDEAD_BEEF;
      if (o_if_ack[i]) if_req[i] = keep_if[i];
      if (o_dm_ack[i]) dm_req[i] = keep_dm[i];
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((o_busy != 2'b00 || if_req != 2'b00 || dm_req != 2'b00) && k < 100) begin
      step();
      k++;
    end
    checks++;
    if (k >= 100) begin
      failures++;
      $display("FAIL idle_timeout busy=%b if_req=%b dm_req=%b exp=all zero", o_busy, if_req, dm_req);
    end
  endtask

  task automatic access(int i, bit dm, bit we, logic [31:0] t, logic [31:0] exp_rd, string tag);
    int L = lat_of(i);
    wait_idle();
    tok[i] = t;
    if (dm) begin
      dm_req[i] = 1'b1;
      dm_we[i]  = we;
    end else begin
      if_req[i] = 1'b1;
    end
    for (int k = 1; k <= L + 3; k++) begin
      step();
      chk({tag, "_en"}, i, 32'(o_en[i]), 32'(k == 1));
      if (k == 1) begin
        chk({tag, "_sel"}, i, 32'(o_sel[i]), 32'(dm));
        chk({tag, "_we"},  i, 32'(o_we[i]),  32'(dm && we));
      end
      chk({tag, "_ifack"}, i, 32'(o_if_ack[i]), 32'(k == L + 2 && !dm));
      chk({tag, "_dmack"}, i, 32'(o_dm_ack[i]), 32'(k == L + 2 && dm));
      chk({tag, "_busy"},  i, 32'(o_busy[i]),   32'(k <= L + 2));
    end
    chk({tag, "_rdata"}, i, dm ? o_dm_rdata[i] : o_if_rdata[i], exp_rd);
    dm_we[i] = 1'b0;
  endtask

  task automatic contention(int i);
    bit exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit seq [$];
    int ack_cyc [$];
    int k = 0;
    wait_idle();
    if_req[i] = 1'b1; dm_req[i] = 1'b1; dm_we[i] = 1'b0;
    keep_dm[i] = 1'b1; keep_if[i] = 1'b0;
    while (seq.size() < 6 && k < 200) begin
      step();
      k++;
      if (o_dm_ack[i]) begin seq.push_back(1'b1); ack_cyc.push_back(cyc); end
      if (o_if_ack[i]) begin seq.push_back(1'b0); ack_cyc.push_back(cyc); end
    end
    keep_dm[i] = 1'b0;
    dm_req[i]  = 1'b0;
    chk("cont_ack_count", i, 32'(seq.size()), 32'd6);
    for (int j = 0; j < seq.size(); j++) chk("cont_grant", j, 32'(seq[j]), 32'(exp_seq[j]));
    if (ack_cyc.size() >= 2) chk("cont_period", i, 32'(ack_cyc[1] - ack_cyc[0]), 32'(lat_of(i) + 3));
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d exp=finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 2'b00; dm_req = 2'b00; dm_we = 2'b00; rnd_tok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = 32'd0; tok[i] = 32'd0; hist[i] = 16'd0;
      keep_if[i] = 1'b0; keep_dm[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy",     i, 32'(o_busy[i]),   32'd0);
      chk("rst_sel",      i, 32'(o_sel[i]),    32'd0);
      chk("rst_en",       i, 32'(o_en[i]),     32'd0);
      chk("rst_if_rdata", i, o_if_rdata[i],    32'd0);
      chk("rst_dm_rdata", i, o_dm_rdata[i],    32'd0);
    end

    for (int i = 0; i < 2; i++) contention(i);

    access(0, 1'b0, 1'b0, 32'h0040_0000, 32'h0040_0000, "if_read");
    access(0, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, "dm_read");
    access(0, 1'b1, 1'b1, 32'hA5A5_0000, 32'h1234_5678, "dm_write");
    access(1, 1'b0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, "lat3_read");

    // reset in the middle of WAIT on the LAT=3 instance
    wait_idle();
    tok[1] = 32'h5555_AAAA;
    if_req[1] = 1'b1;
    step();
    step();
    chk("midrst_busy_before", 1, 32'(o_busy[1]), 32'd1);
    rst = 1'b1;
    if_req[1] = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_busy",  1, 32'(o_busy[1]),   32'd0);
    chk("midrst_rdata", 1, o_if_rdata[1],    32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("midrst_no_ack", 1, 32'(o_if_ack[1]), 32'd0);
    end
    access(1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D, "post_rst_read");

    // randomized traffic, checked every cycle against the model
    rnd_tok = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom % 400 == 0);
      for (int i = 0; i < 2; i++) begin
        keep_if[i] = ($urandom % 3 == 0);
        keep_dm[i] = ($urandom % 3 == 0);
        if (!if_req[i] && ($urandom % 4 == 0)) if_req[i] = 1'b1;
        if (!dm_req[i] && ($urandom % 3 == 0)) begin
          dm_req[i] = 1'b1;
          dm_we[i]  = 1'($urandom % 2);
        end
      end
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin keep_if[i] = 1'b0; keep_dm[i] = 1'b0; end
    wait_idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between the instruction-fetch requester (IF) and the data-memory requester (DM).
- Selects the winner, holds the select for the external 32-bit 2:1 address/data muxes stable for the whole access, and sequences a fixed-latency access.
- Returns read data and a one-cycle ack to the winner.
- DM has priority; an anti-starvation counter guarantees IF progress.

Parameters:
- LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata (1..15).
- MAX_WAIT, 4, consecutive contended DM wins after which IF wins the next contention (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  IF read request; level, held until if_ack.
- if_ack  out  1  one-cycle pulse, IF access complete.
- if_rdata  out  32  IF read data, valid while if_ack=1, held until the next IF ack.
- dm_req  in  1  DM request; level, held until dm_ack.
- dm_we  in  1  DM write enable, qualified by dm_req, held stable with dm_req.
- dm_ack  out  1  one-cycle pulse, DM access complete.
- dm_rdata  out  32  DM read data, valid while dm_ack=1 on reads; not updated on writes.
- mem_sel  out  1  select for the external 2:1 muxes: 0=IF, 1=DM.
- mem_en  out  1  one-cycle memory access strobe.
- mem_we  out  1  memory write strobe; equals mem_en AND winner=DM AND latched dm_we.
- mem_rdata  in  32  memory read data, valid LAT cycles after mem_en.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset values (all outputs and state): state=IDLE, wait counter=0, LAT counter=0, all outputs 0 (mem_sel, mem_en, mem_we, if_ack, dm_ack, busy, if_rdata, dm_rdata).
- All outputs are registered, or decoded from registered state only. No combinational path from any request input to any output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Only one request: that requester wins.
  - Both requests: DM wins unless the wait counter = MAX_WAIT, in which case IF wins.
  - On a win: latch winner into mem_sel, latch dm_we when DM wins, go to ISSUE.
- ISSUE: mem_en=1 for exactly this one cycle. mem_we=1 if winner=DM and the latched we=1. Load the LAT counter with LAT. Go to WAIT.
- WAIT:
  - Occupies exactly LAT cycles; the LAT counter decrements each cycle.
  - On the last WAIT cycle, capture mem_rdata into the winner's rdata register (reads only; writes leave rdata unchanged).
  - Go to RESP.
- RESP: assert the winner's ack for one cycle. Go to IDLE.
- Latency: a request sampled in IDLE at cycle T gives ISSUE at T+1, ack at T+2+LAT, and IDLE again at T+3+LAT. Back-to-back access period is LAT+3 cycles.
- mem_sel is stable from ISSUE through RESP. It updates only on entry to ISSUE and otherwise holds its last value.
- Wait counter:
  - Increments when DM wins while if_req=1.
  - Saturates at MAX_WAIT.
  - Clears when IF wins.
  - Unchanged when DM wins with if_req=0.
- Handshake: requesters drop req in the cycle after seeing ack, so IDLE samples the updated req. If req is still high in IDLE, it is treated as a new request.
- Request or we changes while busy=1 are ignored. Inputs are sampled only in IDLE, except mem_rdata, which is sampled on the last WAIT cycle.
- Reset mid-operation: return to IDLE the next cycle with all outputs 0. No ack is issued for the aborted access. A write already strobed is not undone.
- Simultaneous rst and request: reset wins.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests -> all outputs 0, busy=0, state IDLE indefinitely.
- Single IF read, LAT=1: if_req at T, mem_rdata=0x0040_0000 one cycle after mem_en -> mem_sel=0, mem_en=1 at T+1, if_ack=1 at T+3, if_rdata=0x0040_0000, dm_ack never asserted.
- DM write: dm_req=1, dm_we=1 -> mem_sel=1, mem_en=mem_we=1 for one cycle, dm_ack one cycle at T+2+LAT, dm_rdata unchanged from its previous value.
- Contention/starvation, MAX_WAIT=4: both requests held continuously, DM re-requesting immediately after each ack -> grant order DM,DM,DM,DM,IF,DM..., with if_ack after the 4th dm_ack.
- LAT=3 read: mem_rdata valid only 3 cycles after mem_en (other cycles 0xDEAD_BEEF) -> ack at T+5, captured value correct.
- Reset mid-WAIT: assert rst during WAIT -> next cycle IDLE, no ack, counters 0; a subsequent IF request completes normally.
